// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the interlock/forwarding
// controller (slave): ID/EXE status in, bubble/hold/flush and forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned RF_ADDR_W   = 5,
    parameter int unsigned NUM_FWD_SRC = 4
);
    localparam int unsigned SelW = $clog2(NUM_FWD_SRC);

    logic                 id_valid;
    logic [RF_ADDR_W-1:0] id_rs1;
    logic                 id_rs1_used;
    logic [RF_ADDR_W-1:0] id_rs2;
    logic                 id_rs2_used;
    logic [RF_ADDR_W-1:0] id_rd;
    logic                 id_rf_we;
    logic                 id_is_load;
    logic                 exe_br_taken;
    logic                 exe_busy;

    logic                 id_ready_go;
    logic                 if_id_hold;
    logic                 flush_id;
    logic [SelW-1:0]      fwd_sel1;
    logic [SelW-1:0]      fwd_sel2;
    logic                 exe_valid_o;
    logic                 mem_valid_o;
    logic                 wb_valid_o;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rf_we, id_is_load, exe_br_taken, exe_busy,
        input  id_ready_go, if_id_hold, flush_id, fwd_sel1, fwd_sel2,
               exe_valid_o, mem_valid_o, wb_valid_o
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rf_we, id_is_load, exe_br_taken, exe_busy,
        output id_ready_go, if_id_hold, flush_id, fwd_sel1, fwd_sel2,
               exe_valid_o, mem_valid_o, wb_valid_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage core: EXE/MEM/WB writeback scoreboard,
// load-use/busy stall, branch flush. Define HAZARD_PERF_EN to add stall/flush perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned RF_ADDR_W   = 5,
    parameter int unsigned NUM_FWD_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int unsigned SelW = $clog2(NUM_FWD_SRC);

    localparam logic [SelW-1:0] SelRf  = SelW'(0);
    localparam logic [SelW-1:0] SelExe = SelW'(1);
    localparam logic [SelW-1:0] SelMem = SelW'(2);
    localparam logic [SelW-1:0] SelWb  = SelW'(3);

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } sb_entry_t;

    localparam sb_entry_t Bubble = '0;

    function automatic logic sb_hit(input sb_entry_t            ent,
                                    input logic [RF_ADDR_W-1:0] rs,
                                    input logic                 used);
        return used && (rs != '0) && ent.valid && ent.we && (ent.rd == rs);
    endfunction

    // Youngest producer wins; a load still in EXE has no result to forward yet.
    function automatic logic [SelW-1:0] pick_src(input logic h_e, input logic h_m,
                                                 input logic h_w);
        if (h_e) return SelExe;
        if (h_m) return SelMem;
        if (h_w) return SelWb;
        return SelRf;
    endfunction

    sb_entry_t e_q, e_d;
    sb_entry_t m_q, m_d;
    sb_entry_t w_q, w_d;

    logic hit_e1, hit_m1, hit_w1;
    logic hit_e2, hit_m2, hit_w2;
    logic load_use;
    logic br;
    logic stall;
    logic ready_go;
    logic hold;
    logic [SelW-1:0] sel1, sel2;

    always_comb begin
        hit_e1   = sb_hit(e_q, bus.id_rs1, bus.id_rs1_used);
        hit_m1   = sb_hit(m_q, bus.id_rs1, bus.id_rs1_used);
        hit_w1   = sb_hit(w_q, bus.id_rs1, bus.id_rs1_used);
        hit_e2   = sb_hit(e_q, bus.id_rs2, bus.id_rs2_used);
        hit_m2   = sb_hit(m_q, bus.id_rs2, bus.id_rs2_used);
        hit_w2   = sb_hit(w_q, bus.id_rs2, bus.id_rs2_used);
        load_use = bus.id_valid && e_q.is_load && (hit_e1 || hit_e2);
        br       = bus.exe_br_taken && e_q.valid;
        stall    = load_use || bus.exe_busy;
        ready_go = bus.id_valid && !stall && !br;
        hold     = bus.id_valid && stall && !br;
        sel1     = pick_src(hit_e1 && !e_q.is_load, hit_m1, hit_w1);
        sel2     = pick_src(hit_e2 && !e_q.is_load, hit_m2, hit_w2);
    end

    always_comb begin
        bus.id_ready_go = 1'b0;
        bus.if_id_hold  = 1'b0;
        bus.flush_id    = 1'b0;
        bus.fwd_sel1    = SelRf;
        bus.fwd_sel2    = SelRf;
        bus.exe_valid_o = 1'b0;
        bus.mem_valid_o = 1'b0;
        bus.wb_valid_o  = 1'b0;
        if (!rst) begin
            bus.id_ready_go = ready_go;
            bus.if_id_hold  = hold;
            bus.flush_id    = br;
            bus.fwd_sel1    = sel1;
            bus.fwd_sel2    = sel2;
            bus.exe_valid_o = e_q.valid;
            bus.mem_valid_o = m_q.valid;
            bus.wb_valid_o  = w_q.valid;
        end
    end

    // A busy EXE keeps its entry and feeds MEM a bubble while WB still drains.
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (rst) begin
            e_d = Bubble;
            m_d = Bubble;
            w_d = Bubble;
        end else if (bus.exe_busy) begin
            m_d = Bubble;
            w_d = m_q;
        end else begin
            if (ready_go) begin
                e_d.valid   = 1'b1;
                e_d.rd      = bus.id_rd;
                e_d.we      = bus.id_rf_we;
                e_d.is_load = bus.id_is_load;
            end else begin
                e_d = Bubble;
            end
            m_d = e_q;
            w_d = m_q;
        end
    end

    always_ff @(posedge clk) begin
        e_q <= e_d;
        m_q <= m_d;
        w_q <= w_d;
    end

    // Load flag is meaningless once the result has reached WB.
    logic unused_w_is_load;
    assign unused_w_is_load = w_q.is_load;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
            if (br && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    a_go_hold_excl: assert property (@(posedge clk) disable iff (rst) !(ready_go && hold));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios with literal expectations, then
// randomized traffic checked every cycle against an in-order pipeline model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RF_ADDR_W(AW), .NUM_FWD_SRC(4)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.RF_ADDR_W(AW), .NUM_FWD_SRC(4)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    int n_chk;
    int n_fail;
    bit chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // In-flight instructions, index 0 = EXE (youngest), 2 = WB (oldest).
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } instr_t;

    typedef struct {
        bit go;
        bit hold;
        bit flush;
        bit lu;
        int sel1;
        int sel2;
        bit ev;
        bit mv;
        bit wv;
    } exp_t;

    instr_t st [3];
    exp_t   exp_now;
`ifdef HAZARD_PERF_EN
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;
`endif

    function automatic bit writes(int s, int rs, bit used);
        return used && rs != 0 && st[s].v && st[s].we && st[s].rd == rs;
    endfunction

    function automatic int src_for(int rs, bit used);
        for (int s = 0; s < 3; s++) begin
            if (writes(s, rs, used) && !(s == 0 && st[0].ld)) return s + 1;
        end
        return 0;
    endfunction

    function automatic exp_t model_eval();
        exp_t x;
        bit   br;
        bit   stall;
        x = '{default: 0};
        if (rst) return x;
        br    = bus.exe_br_taken && st[0].v;
        x.lu  = bus.id_valid && st[0].ld &&
                (writes(0, int'(bus.id_rs1), bus.id_rs1_used) ||
                 writes(0, int'(bus.id_rs2), bus.id_rs2_used));
        stall   = x.lu || bus.exe_busy;
        x.go    = bus.id_valid && !stall && !br;
        x.hold  = bus.id_valid && stall && !br;
        x.flush = br;
        x.sel1  = src_for(int'(bus.id_rs1), bus.id_rs1_used);
        x.sel2  = src_for(int'(bus.id_rs2), bus.id_rs2_used);
        x.ev    = st[0].v;
        x.mv    = st[1].v;
        x.wv    = st[2].v;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_now = model_eval();
        if (chk_en) begin
            chk("m_go", bus.id_ready_go, exp_now.go);
            chk("m_hold", bus.if_id_hold, exp_now.hold);
            chk("m_flush", bus.flush_id, exp_now.flush);
            chk("m_ev", bus.exe_valid_o, exp_now.ev);
            chk("m_mv", bus.mem_valid_o, exp_now.mv);
            chk("m_wv", bus.wb_valid_o, exp_now.wv);
            if (!exp_now.lu) begin
                chk("m_sel1", bus.fwd_sel1, exp_now.sel1);
                chk("m_sel2", bus.fwd_sel2, exp_now.sel2);
            end
`ifdef HAZARD_PERF_EN
            chk("m_pstall", perf_stall_cnt, m_stall_cnt);
            chk("m_pflush", perf_flush_cnt, m_flush_cnt);
`endif
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) st[s] <= '{default: 0};
        end else if (bus.exe_busy) begin
            st[1] <= '{default: 0};
            st[2] <= st[1];
        end else begin
            if (exp_now.go)
                st[0] <= '{v: 1'b1, rd: int'(bus.id_rd), we: bus.id_rf_we, ld: bus.id_is_load};
            else
                st[0] <= '{default: 0};
            st[1] <= st[0];
            st[2] <= st[1];
        end
`ifdef HAZARD_PERF_EN
        if (rst) begin
            m_stall_cnt <= '0;
            m_flush_cnt <= '0;
        end else begin
            if (exp_now.hold && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
            if (exp_now.flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt <= m_flush_cnt + 1;
        end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2       = '0;
        bus.id_rs2_used  = 1'b0;
        bus.id_rd        = '0;
        bus.id_rf_we     = 1'b0;
        bus.id_is_load   = 1'b0;
        bus.exe_br_taken = 1'b0;
        bus.exe_busy     = 1'b0;
    endtask

    task automatic set_instr(input bit v, input int rs1, input bit u1, input int rs2,
                             input bit u2, input int rd, input bit we, input bit ld);
        idle();
        bus.id_valid    = v;
        bus.id_rs1      = AW'(rs1);
        bus.id_rs1_used = u1;
        bus.id_rs2      = AW'(rs2);
        bus.id_rs2_used = u2;
        bus.id_rd       = AW'(rd);
        bus.id_rf_we    = we;
        bus.id_is_load  = ld;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        idle();
        step();
        chk_en = 1'b1;

        // Outputs forced low while reset is held, even with live inputs.
        set_instr(1, 5, 1, 5, 1, 5, 1, 0);
        bus.exe_br_taken = 1'b1;
        #1;
        chk("rst_go", bus.id_ready_go, 0);
        chk("rst_hold", bus.if_id_hold, 0);
        chk("rst_flush", bus.flush_id, 0);
        chk("rst_ev", bus.exe_valid_o, 0);
        step();
        rst = 1'b0;

        // ALU result forwarded back-to-back from EXE.
        set_instr(1, 1, 1, 2, 1, 5, 1, 0);
        #1 chk("alu1_go", bus.id_ready_go, 1);
        step();
        set_instr(1, 5, 1, 5, 1, 6, 1, 0);
        #1;
        chk("alu2_go", bus.id_ready_go, 1);
        chk("alu2_sel1", bus.fwd_sel1, 1);
        chk("alu2_sel2", bus.fwd_sel2, 1);
        step();

        // Load-use: one bubble, then forward from MEM.
        set_instr(1, 1, 1, 0, 0, 7, 1, 1);
        #1 chk("ld_go", bus.id_ready_go, 1);
        step();
        set_instr(1, 7, 1, 1, 1, 8, 1, 0);
        #1;
        chk("lu_go", bus.id_ready_go, 0);
        chk("lu_hold", bus.if_id_hold, 1);
        step();
        #1;
        chk("lu2_go", bus.id_ready_go, 1);
        chk("lu2_sel1", bus.fwd_sel1, 2);
        chk("lu2_sel2", bus.fwd_sel2, 0);
        step();

        // r3 written three issues back lands in WB; r0 never forwards.
        set_instr(1, 2, 1, 4, 1, 3, 1, 0);
        #1 chk("w3_go", bus.id_ready_go, 1);
        step();
        set_instr(1, 2, 1, 4, 1, 0, 1, 0);
        step();
        set_instr(1, 0, 1, 0, 1, 10, 1, 0);
        #1;
        chk("r0_go", bus.id_ready_go, 1);
        chk("r0_sel1", bus.fwd_sel1, 0);
        chk("r0_sel2", bus.fwd_sel2, 0);
        step();
        set_instr(1, 3, 1, 0, 1, 11, 1, 0);
        #1;
        chk("wb_sel1", bus.fwd_sel1, 3);
        chk("wb_sel2", bus.fwd_sel2, 0);
        step();

        // Taken branch with a valid EXE entry flushes and bubbles.
        set_instr(1, 1, 1, 2, 1, 12, 1, 0);
        bus.exe_br_taken = 1'b1;
        #1;
        chk("br_flush", bus.flush_id, 1);
        chk("br_go", bus.id_ready_go, 0);
        chk("br_hold", bus.if_id_hold, 0);
        step();
        idle();
        #1 chk("br_ev", bus.exe_valid_o, 0);
        step();
        idle();
        bus.exe_br_taken = 1'b1;
        #1 chk("br_inv_flush", bus.flush_id, 0);
        step();

        // Busy EXE holds r9 for three cycles; dependant then forwards from EXE.
        set_instr(1, 1, 1, 2, 1, 9, 1, 0);
        #1 chk("r9_go", bus.id_ready_go, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_instr(1, 9, 1, 9, 1, 13, 1, 0);
            bus.exe_busy = 1'b1;
            #1;
            chk("busy_hold", bus.if_id_hold, 1);
            chk("busy_go", bus.id_ready_go, 0);
            chk("busy_mv", bus.mem_valid_o, 0);
            chk("busy_ev", bus.exe_valid_o, 1);
            step();
        end
        set_instr(1, 9, 1, 9, 1, 13, 1, 0);
        #1;
        chk("rel_go", bus.id_ready_go, 1);
        chk("rel_sel1", bus.fwd_sel1, 1);
        chk("rel_sel2", bus.fwd_sel2, 1);
        step();

        // Reset during a load-use stall empties the scoreboard.
        set_instr(1, 0, 0, 0, 0, 11, 1, 1);
        step();
        set_instr(1, 11, 1, 0, 0, 12, 1, 0);
        #1 chk("rlu_hold", bus.if_id_hold, 1);
        rst = 1'b1;
        #1;
        chk("rlu_rst_go", bus.id_ready_go, 0);
        chk("rlu_rst_hold", bus.if_id_hold, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rlu_ev", bus.exe_valid_o, 0);
        chk("rlu_mv", bus.mem_valid_o, 0);
        chk("rlu_wv", bus.wb_valid_o, 0);
        chk("rlu_hold2", bus.if_id_hold, 0);
        chk("rlu_go2", bus.id_ready_go, 1);
        chk("rlu_sel1", bus.fwd_sel1, 0);
`ifdef HAZARD_PERF_EN
        chk("perf_rst_stall", perf_stall_cnt, 0);
        chk("perf_rst_flush", perf_flush_cnt, 0);
`endif
        step();
        bus.exe_busy = 1'b1;
        repeat (5) step();
        bus.exe_busy = 1'b0;
        #1;
`ifdef HAZARD_PERF_EN
        chk("perf_stall5", perf_stall_cnt, 5);
        chk("perf_flush0", perf_flush_cnt, 0);
`endif
        chk("post_busy_go", bus.id_ready_go, 1);
        step();

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_rs1       = AW'($urandom_range(0, 7));
            bus.id_rs1_used  = ($urandom_range(0, 3) != 0);
            bus.id_rs2       = AW'($urandom_range(0, 7));
            bus.id_rs2_used  = ($urandom_range(0, 1) != 0);
            bus.id_rd        = AW'($urandom_range(0, 7));
            bus.id_rf_we     = ($urandom_range(0, 4) != 0);
            bus.id_is_load   = ($urandom_range(0, 2) == 0);
            bus.exe_br_taken = ($urandom_range(0, 7) == 0);
            bus.exe_busy     = !bus.exe_br_taken && ($urandom_range(0, 5) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
